// File: rtl/store_trace_checker_pkg.sv
// Shared types and default constants for the MIPS store-trace checker.
package store_trace_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REC_W  = ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] DEF_PASS_ADDR    = 32'd84;
  localparam logic [DATA_W-1:0] DEF_PASS_DATA    = 32'd7;
  localparam logic [ADDR_W-1:0] DEF_SCRATCH_ADDR = 32'd80;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } verdict_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_rec_t;

endpackage

// File: rtl/store_trace_checker_if.sv
// Store tap (from the processor) plus the valid/ready trace drain port.
interface store_trace_checker_if;
  import store_trace_pkg::*;

  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;
  logic              trc_valid;
  logic              trc_ready;
  logic [ADDR_W-1:0] trc_addr;
  logic [DATA_W-1:0] trc_data;

  // master: the environment (processor tap + trace consumer)
  modport master (
    output memwrite, dataadr, writedata, trc_ready,
    input  trc_valid, trc_addr, trc_data
  );

  // slave: the checker
  modport slave (
    input  memwrite, dataadr, writedata, trc_ready,
    output trc_valid, trc_addr, trc_data
  );

endinterface

// File: rtl/store_trace_checker_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit full/empty detection.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/store_trace_checker.sv
// Taps the MIPS data-memory write bus, traces stores into a FIFO and
// reaches a sticky pass/fail verdict from the program's completion store.
module store_trace_checker
  import store_trace_pkg::*;
#(
  parameter int unsigned       DEPTH        = 8,
  parameter logic [ADDR_W-1:0] PASS_ADDR    = DEF_PASS_ADDR,
  parameter logic [DATA_W-1:0] PASS_DATA    = DEF_PASS_DATA,
  parameter logic [ADDR_W-1:0] SCRATCH_ADDR = DEF_SCRATCH_ADDR,
  parameter int unsigned       CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  store_trace_checker_if.slave bus,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 overflow,
  output logic [CNT_W-1:0]     store_count
);

  verdict_t   state;
  verdict_t   next_state;
  logic       capture_c;
  logic       pop_c;
  logic       fifo_full;
  logic       fifo_empty;
  trace_rec_t push_rec;
  trace_rec_t head_rec;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= next_state;
  end

  // Verdict decision; PASS_ADDR with the wrong data is tolerated.
  always_comb begin
    next_state = state;
    if (state == ST_RUN && bus.memwrite) begin
      if (bus.dataadr == PASS_ADDR && bus.writedata == PASS_DATA)
        next_state = ST_PASS;
      else if (bus.dataadr != SCRATCH_ADDR && bus.dataadr != PASS_ADDR)
        next_state = ST_FAIL;
    end
  end

  // Stores are captured only while running, including the deciding one.
  always_comb begin
    capture_c = 1'b0;
    if (state == ST_RUN) capture_c = bus.memwrite;
  end

  assign pop_c         = !fifo_empty && bus.trc_ready;
  assign push_rec.addr = bus.dataadr;
  assign push_rec.data = bus.writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      overflow    <= 1'b0;
      store_count <= '0;
    end else begin
      done <= (next_state != ST_RUN);
      pass <= (next_state == ST_PASS);
      fail <= (next_state == ST_FAIL);
      if (capture_c && fifo_full && !pop_c) overflow <= 1'b1;
      if (capture_c && store_count != '1) store_count <= store_count + CNT_W'(1);
    end
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture_c),
    .push_data (push_rec),
    .pop       (pop_c),
    .pop_data  (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head fields read as zero while empty so reset shows all-zero outputs.
  assign bus.trc_valid = !fifo_empty;
  assign bus.trc_addr  = fifo_empty ? '0 : head_rec.addr;
  assign bus.trc_data  = fifo_empty ? '0 : head_rec.data;

endmodule

// File: tb/tb_store_trace_checker.sv
// Directed bench for store_trace_checker: queue-based reference model plus literal checkpoints.
module tb_store_trace_checker;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             done, pass, fail, overflow;
  logic [CNT_W-1:0] store_count;

  store_trace_checker_if bus ();

  store_trace_checker #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .overflow    (overflow),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: verdict 0=running 1=pass 2=fail; queue holds {addr,data}.
  logic [63:0] mq[$];
  int          m_verdict = 0;
  int          m_count   = 0;
  bit          m_ovf     = 1'b0;

  always @(posedge clk) begin
    bit do_pop, take;
    if (reset) begin
      mq.delete();
      m_verdict = 0;
      m_count   = 0;
      m_ovf     = 1'b0;
    end else begin
      do_pop = (mq.size() > 0) && bus.trc_ready;
      take   = bus.memwrite && (m_verdict == 0);
      if (do_pop) void'(mq.pop_front());
      if (take) begin
        if (m_count < 65535) m_count = m_count + 1;
        if (mq.size() >= DEPTH) m_ovf = 1'b1;
        else mq.push_back({bus.dataadr, bus.writedata});
        if (bus.dataadr == 32'd84 && bus.writedata == 32'd7) m_verdict = 1;
        else if (bus.dataadr != 32'd80 && bus.dataadr != 32'd84) m_verdict = 2;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("trc_valid", 64'(bus.trc_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("trc_addr", 64'(bus.trc_addr), 64'(mq[0][63:32]));
        check("trc_data", 64'(bus.trc_data), 64'(mq[0][31:0]));
      end
      check("done", 64'(done), 64'(m_verdict != 0));
      check("pass", 64'(pass), 64'(m_verdict == 1));
      check("fail", 64'(fail), 64'(m_verdict == 2));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("store_count", 64'(store_count), 64'(m_count));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.dataadr   = a;
    bus.writedata = d;
    step();
    bus.memwrite  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    bus.trc_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_valid", 64'(bus.trc_valid), 64'd0);
    check("rst_addr", 64'(bus.trc_addr), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(store_count), 64'd0);
    chk_en = 1'b1;

    // Scratch store then the pass store, consumer always ready
    bus.trc_ready = 1'b1;
    do_store(32'd80, 32'd5);
    check("t1_head_addr0", 64'(bus.trc_addr), 64'd80);
    check("t1_head_data0", 64'(bus.trc_data), 64'd5);
    check("t1_pass_early", 64'(pass), 64'd0);
    do_store(32'd84, 32'd7);
    check("t1_pass", 64'(pass), 64'd1);
    check("t1_done", 64'(done), 64'd1);
    check("t1_fail", 64'(fail), 64'd0);
    check("t1_count", 64'(store_count), 64'd2);
    check("t1_head_addr1", 64'(bus.trc_addr), 64'd84);
    check("t1_head_data1", 64'(bus.trc_data), 64'd7);
    step();
    check("t1_drained", 64'(bus.trc_valid), 64'd0);

    // Wrong data at PASS_ADDR is tolerated; a stray address fails
    do_reset();
    check("t2_count_rst", 64'(store_count), 64'd0);
    do_store(32'd84, 32'd3);
    check("t2_run_done", 64'(done), 64'd0);
    do_store(32'd120, 32'd9);
    check("t2_fail", 64'(fail), 64'd1);
    check("t2_pass", 64'(pass), 64'd0);
    check("t2_count", 64'(store_count), 64'd2);

    // Ten stores with no consumer: two dropped, overflow after the ninth
    do_reset();
    bus.trc_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_store(32'd80, 32'(100 + i));
      if (i == 7) check("t3_ovf_at8", 64'(overflow), 64'd0);
      if (i == 8) check("t3_ovf_at9", 64'(overflow), 64'd1);
    end
    check("t3_count", 64'(store_count), 64'd10);
    bus.trc_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t3_drain", 64'(bus.trc_data), 64'(100 + i));
      step();
    end
    check("t3_empty", 64'(bus.trc_valid), 64'd0);

    // Full FIFO with a push and a pop on the same edge
    do_reset();
    bus.trc_ready = 1'b0;
    for (int i = 0; i < 8; i++) do_store(32'd80, 32'(200 + i));
    bus.trc_ready = 1'b1;
    do_store(32'd80, 32'd300);
    bus.trc_ready = 1'b0;
    check("t4_ovf", 64'(overflow), 64'd0);
    check("t4_head", 64'(bus.trc_data), 64'd201);
    bus.trc_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t4_drain", 64'(bus.trc_data), (i == 7) ? 64'd300 : 64'(201 + i));
      step();
    end
    check("t4_empty", 64'(bus.trc_valid), 64'd0);

    // Stores after the verdict are ignored
    do_reset();
    do_store(32'd84, 32'd7);
    check("t5_pass", 64'(pass), 64'd1);
    do_store(32'd200, 32'd1);
    do_store(32'd84, 32'd7);
    check("t5_count", 64'(store_count), 64'd1);
    check("t5_pass_hold", 64'(pass), 64'd1);
    check("t5_fail_hold", 64'(fail), 64'd0);
    check("t5_no_push", 64'(bus.trc_valid), 64'd0);

    // Reset with entries queued and a failure latched; store in reset cycle is ignored
    do_reset();
    bus.trc_ready = 1'b0;
    do_store(32'd80, 32'd1);
    do_store(32'd80, 32'd2);
    do_store(32'd80, 32'd3);
    do_store(32'd120, 32'd4);
    check("t6_fail", 64'(fail), 64'd1);
    reset         = 1'b1;
    bus.memwrite  = 1'b1;
    bus.dataadr   = 32'd84;
    bus.writedata = 32'd7;
    step();
    reset        = 1'b0;
    bus.memwrite = 1'b0;
    check("t6_valid", 64'(bus.trc_valid), 64'd0);
    check("t6_fail_clr", 64'(fail), 64'd0);
    check("t6_pass_clr", 64'(pass), 64'd0);
    check("t6_done_clr", 64'(done), 64'd0);
    check("t6_ovf_clr", 64'(overflow), 64'd0);
    check("t6_count_clr", 64'(store_count), 64'd0);
    do_store(32'd84, 32'd7);
    check("t6_pass", 64'(pass), 64'd1);
    step();

    @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
